// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  // Loader control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  // Bytes packed into one instruction word
  localparam int WORD_BYTES = 4;

  // 4KB image expressed in 32-bit words
  localparam int DEPTH_WORDS_DEFAULT = 1024;

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_word_packer
//  Description : Collects a little-endian byte stream into 32-bit words and
//                flags the cycle in which the last lane of a word arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  localparam int                 c_LANE_BITS = $clog2(WORD_BYTES);
  localparam logic [c_LANE_BITS-1:0] c_LAST_LANE = c_LANE_BITS'(WORD_BYTES - 1);

  logic [c_LANE_BITS-1:0]       byte_idx_q;
  logic [8*(WORD_BYTES-1)-1:0]  w_lanes;

  // Lane pointer: advances per accepted byte and wraps naturally after the last lane
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_q <= '0;
    end else if (clear_i) begin
      byte_idx_q <= '0;
    end else if (accept_i) begin
      byte_idx_q <= byte_idx_q + 1'b1;
    end
  end

  // Only the lower lanes need storage; the top lane is taken straight from the input
  generate
    for (genvar i = 0; i < WORD_BYTES - 1; i++) begin : g_lane
      logic [7:0] lane_q;

      // Capture the byte when the pointer selects this lane
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_q <= '0;
        end else if (accept_i && !clear_i && (byte_idx_q == c_LANE_BITS'(i))) begin
          lane_q <= byte_i;
        end
      end

      assign w_lanes[8*i +: 8] = lane_q;
    end
  endgenerate

  assign word_o       = {byte_i, w_lanes};
  assign word_ready_o = accept_i && !clear_i && (byte_idx_q == c_LAST_LANE);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Write side of the instruction memory. Packs a firmware byte
//                stream into words, writes them to the RAM port, holds the CPU
//                while loading and keeps a running checksum of written words.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          COUNT_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   loadStart,
  input  logic                   loadAbort,
  input  logic [COUNT_WIDTH-1:0] loadWordCount,
  input  logic                   byteValid,
  input  logic [7:0]             byteData,
  output logic                   byteReady,
  output logic                   memWriteEnable,
  output logic [31:0]            memWriteAddress,
  output logic [31:0]            memWriteData,
  output logic                   cpuHold,
  output logic                   loadBusy,
  output logic                   loadDone,
  output logic                   loadError,
  output logic [31:0]            checksum
);

  localparam logic [COUNT_WIDTH-1:0] c_DEPTH = COUNT_WIDTH'(DEPTH_WORDS);

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   count_q;
  logic [COUNT_WIDTH-1:0]   word_idx_q;
  logic                     wen_q;
  logic [31:0]              waddr_q;
  logic [31:0]              wdata_q;
  logic [31:0]              checksum_q;

  logic                     w_count_ok;
  logic                     w_start_acc;
  logic                     w_abort_acc;
  logic                     w_accept;
  logic                     w_word_ready;
  logic [31:0]              w_word;
  logic                     w_issue;
  logic                     w_final_write;

  assign w_count_ok    = (loadWordCount != '0) && (loadWordCount <= c_DEPTH);
  assign w_start_acc   = loadStart && (state_q != ST_LOAD);
  assign w_abort_acc   = loadAbort && (state_q == ST_LOAD);
  assign w_accept      = byteValid && byteReady;
  // An abort in the same cycle as the completing byte suppresses the write
  assign w_issue       = w_word_ready && (state_q == ST_LOAD) && !loadAbort;
  assign w_final_write = wen_q && (word_idx_q == count_q - 1'b1);

  byte_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (w_start_acc || w_abort_acc),
    .accept_i     (w_accept),
    .byte_i       (byteData),
    .word_o       (w_word),
    .word_ready_o (w_word_ready)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded status outputs
  always_comb begin
    state_d   = state_q;
    byteReady = 1'b0;
    loadBusy  = 1'b0;
    loadDone  = 1'b0;
    loadError = 1'b0;
    cpuHold   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (loadStart) state_d = w_count_ok ? ST_LOAD : ST_ERROR;
      end
      ST_LOAD: begin
        byteReady = 1'b1;
        loadBusy  = 1'b1;
        cpuHold   = 1'b1;
        if (loadAbort)          state_d = ST_ERROR;
        else if (w_final_write) state_d = ST_DONE;
      end
      ST_DONE: begin
        loadDone = 1'b1;
        if (loadStart) state_d = w_count_ok ? ST_LOAD : ST_ERROR;
      end
      ST_ERROR: begin
        loadError = 1'b1;
        cpuHold   = 1'b1;
        if (loadStart) state_d = w_count_ok ? ST_LOAD : ST_ERROR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write port register: one-cycle strobe with address/data held for that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= w_issue;
      if (w_issue) begin
        wdata_q <= w_word;
        waddr_q <= BASE_ADDR + (32'(word_idx_q) << 2);
      end
    end
  end

  // Word index, latched count and checksum; a new load restarts all three
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      word_idx_q <= '0;
      checksum_q <= '0;
    end else if (w_start_acc) begin
      count_q    <= loadWordCount;
      word_idx_q <= '0;
      checksum_q <= '0;
    end else if (wen_q) begin
      word_idx_q <= word_idx_q + 1'b1;
      checksum_q <= checksum_q + wdata_q;
    end
  end

  assign memWriteEnable  = wen_q;
  assign memWriteAddress = waddr_q;
  assign memWriteData    = wdata_q;
  assign checksum        = checksum_q;

endmodule
`default_nettype wire
